// File: rtl/draw_background_pattern_pkg.sv
// rtl/draw_background_pattern_pkg.sv - shared mode encodings, config word and colour tables
package draw_background_pattern_pkg;

    typedef enum logic [2:0] {
        MODE_BORDER   = 3'd0,
        MODE_SOLID    = 3'd1,
        MODE_BARS     = 3'd2,
        MODE_CHECKER  = 3'd3,
        MODE_GRADIENT = 3'd4
    } mode_e;

    typedef struct packed {
        mode_e       mode;
        logic        scroll_en;
        logic [11:0] color;
    } cfg_word_t;

    localparam logic [11:0] BORDER_TOP    = 12'hff0;
    localparam logic [11:0] BORDER_BOTTOM = 12'hf00;
    localparam logic [11:0] BORDER_LEFT   = 12'h0f0;
    localparam logic [11:0] BORDER_RIGHT  = 12'h00f;
    localparam logic [11:0] BORDER_FILL   = 12'hfff;
    localparam logic [11:0] RGB_BLACK     = 12'h000;

    function automatic logic [11:0] bar_color(input logic [2:0] idx);
        logic [11:0] c;
        case (idx)
            3'd0:    c = 12'hfff;
            3'd1:    c = 12'hff0;
            3'd2:    c = 12'h0ff;
            3'd3:    c = 12'h0f0;
            3'd4:    c = 12'hf0f;
            3'd5:    c = 12'hf00;
            3'd6:    c = 12'h00f;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/draw_background_cfg.sv
// rtl/draw_background_cfg.sv - config handshake, one-entry pending slot, frame boundary and frame counter
module draw_background_cfg
    import draw_background_pattern_pkg::*;
#(
    parameter int CNT_W = 12
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             vsync_in,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [2:0]       cfg_mode,
    input  logic             cfg_scroll_en,
    input  logic [11:0]      cfg_color,
    output cfg_word_t        act_cfg,
    output logic [CNT_W-1:0] frame_cnt
);

    cfg_word_t        pend_q, pend_d;
    cfg_word_t        act_q, act_d;
    logic             pend_valid_q, pend_valid_d;
    logic             vsync_q, vsync_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             boundary;
    logic             accept;

    // A full slot can still take a word on the boundary cycle because it drains that same cycle.
    assign boundary  = vsync_in && !vsync_q;
    assign cfg_ready = !pend_valid_q || boundary;
    assign accept    = cfg_valid && cfg_ready;
    assign act_cfg   = act_q;
    assign frame_cnt = frame_cnt_q;

    always_comb begin
        vsync_d      = vsync_in;
        frame_cnt_d  = frame_cnt_q;
        act_d        = act_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        if (boundary) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            if (pend_valid_q) begin
                act_d        = pend_q;
                pend_valid_d = 1'b0;
            end
        end
        if (accept) begin
            pend_d       = '{mode: mode_e'(cfg_mode), scroll_en: cfg_scroll_en, color: cfg_color};
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            vsync_q      <= 1'b0;
            frame_cnt_q  <= '0;
            act_q        <= '{mode: MODE_BORDER, scroll_en: 1'b0, color: 12'h000};
            pend_q       <= '{mode: MODE_BORDER, scroll_en: 1'b0, color: 12'h000};
            pend_valid_q <= 1'b0;
        end else begin
            vsync_q      <= vsync_d;
            frame_cnt_q  <= frame_cnt_d;
            act_q        <= act_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
        end
    end

endmodule

// File: rtl/draw_background_pattern.sv
// rtl/draw_background_pattern.sv - two-stage background pattern pipeline with frame-aligned configuration
module draw_background_pattern
    import draw_background_pattern_pkg::*;
#(
    parameter int H_ACTIVE    = 1024,
    parameter int V_ACTIVE    = 768,
    parameter int CNT_W       = 12,
    parameter int CELL_LOG2   = 5,
    parameter int SCROLL_STEP = 2
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic [CNT_W-1:0] hcount_in,
    input  logic [CNT_W-1:0] vcount_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             hblnk_in,
    input  logic             vblnk_in,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [2:0]       cfg_mode,
    input  logic             cfg_scroll_en,
    input  logic [11:0]      cfg_color,
    output logic [CNT_W-1:0] hcount_out,
    output logic [CNT_W-1:0] vcount_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             hblnk_out,
    output logic             vblnk_out,
    output logic [11:0]      rgb_out
);

    localparam int               TW        = 2 * CNT_W + 4;
    localparam logic [CNT_W-1:0] BAR_W     = CNT_W'(H_ACTIVE / 8);
    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] STEP      = CNT_W'(SCROLL_STEP);
    localparam logic [CNT_W-1:0] CELL_MASK = CNT_W'(1) << CELL_LOG2;

    cfg_word_t        act_cfg;
    logic [CNT_W-1:0] frame_cnt;

    draw_background_cfg #(.CNT_W(CNT_W)) u_cfg (
        .pclk          (pclk),
        .reset         (reset),
        .vsync_in      (vsync_in),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_mode      (cfg_mode),
        .cfg_scroll_en (cfg_scroll_en),
        .cfg_color     (cfg_color),
        .act_cfg       (act_cfg),
        .frame_cnt     (frame_cnt)
    );

    logic [TW-1:0]    tim_s1_q, tim_s1_d, tim_out_q, tim_out_d;
    logic [11:0]      rgb_s1_q, rgb_s1_d, rgb_out_q, rgb_out_d;
    logic [CNT_W-1:0] offset, bar_idx;
    logic [2:0]       bar_sel;
    logic [3:0]       grad;
    logic             checker_odd;
    logic [11:0]      border_px;

    // Stage 1: pattern colour from the raw counters and the configuration in force this cycle.
    always_comb begin
        offset      = act_cfg.scroll_en ? frame_cnt * STEP : '0;
        bar_idx     = hcount_in / BAR_W;
        bar_sel     = (bar_idx > CNT_W'(7)) ? 3'd7 : bar_idx[2:0];
        grad        = hcount_in[CNT_W-3 -: 4];
        checker_odd = (((hcount_in + offset) ^ vcount_in) & CELL_MASK) != '0;

        if (vcount_in == '0)          border_px = BORDER_TOP;
        else if (vcount_in == V_LAST) border_px = BORDER_BOTTOM;
        else if (hcount_in == '0)     border_px = BORDER_LEFT;
        else if (hcount_in == H_LAST) border_px = BORDER_RIGHT;
        else                          border_px = BORDER_FILL;

        case (act_cfg.mode)
            MODE_SOLID:    rgb_s1_d = act_cfg.color;
            MODE_BARS:     rgb_s1_d = bar_color(bar_sel);
            MODE_CHECKER:  rgb_s1_d = checker_odd ? RGB_BLACK : BORDER_FILL;
            MODE_GRADIENT: rgb_s1_d = {grad, grad, grad};
            default:       rgb_s1_d = border_px;
        endcase

        tim_s1_d = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
    end

    // Stage 2: blanking is judged on the delayed strobes that leave alongside the pixel.
    always_comb begin
        tim_out_d = tim_s1_q;
        rgb_out_d = (tim_s1_q[1] || tim_s1_q[0]) ? RGB_BLACK : rgb_s1_q;
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            tim_s1_q  <= '0;
            rgb_s1_q  <= '0;
            tim_out_q <= '0;
            rgb_out_q <= '0;
        end else begin
            tim_s1_q  <= tim_s1_d;
            rgb_s1_q  <= rgb_s1_d;
            tim_out_q <= tim_out_d;
            rgb_out_q <= rgb_out_d;
        end
    end

    assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = tim_out_q;
    assign rgb_out = rgb_out_q;

endmodule

// File: tb/tb_draw_background_pattern.sv
// tb/tb_draw_background_pattern.sv - directed, table-driven bench for draw_background_pattern
module tb_draw_background_pattern;

    localparam int H = 128;
    localparam int V = 6;
    localparam int H_TOT = 144;
    localparam int V_TOT = 8;

    logic        pclk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
    logic        cfg_valid = 1'b0, cfg_ready, cfg_scroll_en = 1'b0;
    logic [2:0]  cfg_mode = '0;
    logic [11:0] cfg_color = '0;
    logic [11:0] hcount_out, vcount_out, rgb_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;

    draw_background_pattern #(
        .H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(12), .CELL_LOG2(5), .SCROLL_STEP(2)
    ) dut (
        .pclk(pclk), .reset(reset),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_mode(cfg_mode), .cfg_scroll_en(cfg_scroll_en), .cfg_color(cfg_color),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    always #5 pclk = ~pclk;

    int errors = 0;
    int checks = 0;
    int h = 0, v = 0;
    bit acc;

    // Output capture: last frame's active pixels, plus running latency and blanking error tallies.
    logic [11:0] fb [0:V-1][0:H-1];
    logic [27:0] hist1, hist2;
    int quiet = 2;
    int lat_err = 0, blank_err = 0;

    always @(negedge pclk) begin
        if (reset) begin
            quiet = 2;
        end else if (quiet > 0) begin
            quiet--;
        end else begin
            if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} !== hist2)
                lat_err++;
            if ((hblnk_out || vblnk_out) && rgb_out !== 12'h000)
                blank_err++;
            if (!hblnk_out && !vblnk_out && hcount_out < H && vcount_out < V)
                fb[vcount_out][hcount_out] = rgb_out;
        end
        hist2 = hist1;
        hist1 = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive();
        hcount_in = 12'(h);
        vcount_in = 12'(v);
        hblnk_in  = (h >= H);
        hsync_in  = (h >= 132 && h < 140);
        vblnk_in  = (v >= V);
        vsync_in  = (v == V_TOT - 1);
    endtask

    task automatic cycle();
        @(negedge pclk);
        acc = cfg_valid && cfg_ready;
        @(posedge pclk);
        #1;
        if (acc) cfg_valid = 1'b0;
        h++;
        if (h == H_TOT) begin
            h = 0;
            v++;
            if (v == V_TOT) v = 0;
        end
        drive();
    endtask

    task automatic finish_frame();
        do cycle(); while (!(h == 0 && v == 0));
    endtask

    task automatic cycle_to_line(input int line);
        while (v != line) cycle();
    endtask

    task automatic submit(input logic [2:0] m, input logic s, input logic [11:0] c, output int waited);
        cfg_mode = m; cfg_scroll_en = s; cfg_color = c; cfg_valid = 1'b1;
        waited = 0;
        forever begin
            cycle();
            if (acc) break;
            waited++;
            if (waited > 3000) begin
                chk("submit_timeout", 32'(waited), 0);
                cfg_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        cfg_valid = 1'b0;
        hcount_in = 12'h005; vcount_in = 12'h003;
        hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b0; vblnk_in = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        chk({tag, "_hcount_out"}, 32'(hcount_out), 0);
        chk({tag, "_vcount_out"}, 32'(vcount_out), 0);
        chk({tag, "_strobes_out"}, {28'd0, hsync_out, vsync_out, hblnk_out, vblnk_out}, 0);
        chk({tag, "_rgb_out"}, 32'(rgb_out), 0);
        h = 0; v = 0;
        drive();
        @(posedge pclk);
        #1;
        reset = 1'b0;
        #1;
        chk({tag, "_cfg_ready"}, 32'(cfg_ready), 1);
    endtask

    typedef struct {
        logic [2:0]  m;
        logic        s;
        logic [11:0] c;
        int          x;
        int          y;
        logic [11:0] e;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [2:0]  cur_m;
        logic        cur_s;
        logic [11:0] cur_c;
        bit          first;
        int          w;
        int          bad;

        vecs.push_back('{3'd0, 1'b0, 12'h000,   0, 0, 12'hff0});
        vecs.push_back('{3'd0, 1'b0, 12'h000, 127, 0, 12'hff0});
        vecs.push_back('{3'd0, 1'b0, 12'h000,   5, 5, 12'hf00});
        vecs.push_back('{3'd0, 1'b0, 12'h000,   0, 5, 12'hf00});
        vecs.push_back('{3'd0, 1'b0, 12'h000,   0, 3, 12'h0f0});
        vecs.push_back('{3'd0, 1'b0, 12'h000, 127, 3, 12'h00f});
        vecs.push_back('{3'd0, 1'b0, 12'h000,   5, 3, 12'hfff});
        vecs.push_back('{3'd2, 1'b0, 12'h000,   0, 2, 12'hfff});
        vecs.push_back('{3'd2, 1'b0, 12'h000,  15, 2, 12'hfff});
        vecs.push_back('{3'd2, 1'b0, 12'h000,  16, 2, 12'hff0});
        vecs.push_back('{3'd2, 1'b0, 12'h000,  40, 1, 12'h0ff});
        vecs.push_back('{3'd2, 1'b0, 12'h000,  48, 3, 12'h0f0});
        vecs.push_back('{3'd2, 1'b0, 12'h000,  64, 3, 12'hf0f});
        vecs.push_back('{3'd2, 1'b0, 12'h000,  80, 0, 12'hf00});
        vecs.push_back('{3'd2, 1'b0, 12'h000,  96, 4, 12'h00f});
        vecs.push_back('{3'd2, 1'b0, 12'h000, 112, 4, 12'h000});
        vecs.push_back('{3'd2, 1'b0, 12'h000, 127, 5, 12'h000});
        vecs.push_back('{3'd4, 1'b0, 12'h000,   0, 1, 12'h000});
        vecs.push_back('{3'd4, 1'b0, 12'h000,  63, 1, 12'h000});
        vecs.push_back('{3'd4, 1'b0, 12'h000,  64, 1, 12'h111});
        vecs.push_back('{3'd4, 1'b0, 12'h000, 127, 4, 12'h111});
        vecs.push_back('{3'd3, 1'b0, 12'h000,   0, 0, 12'hfff});
        vecs.push_back('{3'd3, 1'b0, 12'h000,  31, 0, 12'hfff});
        vecs.push_back('{3'd3, 1'b0, 12'h000,  32, 0, 12'h000});
        vecs.push_back('{3'd3, 1'b0, 12'h000,  64, 5, 12'hfff});
        vecs.push_back('{3'd1, 1'b0, 12'h123,   7, 2, 12'h123});
        vecs.push_back('{3'd5, 1'b0, 12'h000,   0, 0, 12'hff0});
        vecs.push_back('{3'd5, 1'b0, 12'h000,   5, 3, 12'hfff});

        do_reset("rst0");

        cur_m = 3'd0; cur_s = 1'b0; cur_c = 12'h000; first = 1'b1;
        foreach (vecs[i]) begin
            if (vecs[i].m != cur_m || vecs[i].s != cur_s || vecs[i].c != cur_c) begin
                submit(vecs[i].m, vecs[i].s, vecs[i].c, w);
                finish_frame();
                finish_frame();
                cur_m = vecs[i].m; cur_s = vecs[i].s; cur_c = vecs[i].c;
                first = 1'b0;
            end else if (first) begin
                finish_frame();
                first = 1'b0;
            end
            chk($sformatf("vec%0d_mode%0d_x%0d_y%0d", i, vecs[i].m, vecs[i].x, vecs[i].y),
                32'(fb[vecs[i].y][vecs[i].x]), 32'(vecs[i].e));
        end

        // Solid word accepted mid-frame must not touch the frame already in flight.
        cycle_to_line(2);
        submit(3'd1, 1'b0, 12'h5a3, w);
        finish_frame();
        bad = 0;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                if (fb[y][x] == 12'h5a3) bad++;
        chk("solid_current_frame_untouched", 32'(bad), 0);
        chk("solid_current_frame_fill", 32'(fb[3][5]), 32'h fff);
        finish_frame();
        bad = 0;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                if (fb[y][x] !== 12'h5a3) bad++;
        chk("solid_next_frame_all_pixels", 32'(bad), 0);

        // Back-to-back words: second stalls until the boundary and lands one frame later.
        cycle_to_line(1);
        submit(3'd2, 1'b0, 12'h000, w);
        chk("b2b_first_wait", 32'(w), 0);
        submit(3'd4, 1'b0, 12'h000, w);
        chk("b2b_second_stalled", 32'(w > 0), 1);
        chk("b2b_second_at_boundary", 32'(v * 1000 + h), 32'((V_TOT - 1) * 1000 + 1));
        finish_frame();
        finish_frame();
        chk("b2b_frame1_bars", 32'(fb[0][16]), 32'h ff0);
        chk("b2b_frame1_not_gradient", 32'(fb[0][64]), 32'h f0f);
        finish_frame();
        chk("b2b_frame2_gradient", 32'(fb[0][64]), 32'h111);

        // Reset with a word still pending: it must be dropped.
        cycle_to_line(2);
        submit(3'd1, 1'b0, 12'habc, w);
        repeat (10) cycle();
        do_reset("rst1");
        finish_frame();
        chk("rst_frame0_mode0", 32'(fb[3][5]), 32'h fff);
        finish_frame();
        chk("rst_frame1_mode0", 32'(fb[3][5]), 32'h fff);
        chk("rst_frame1_corner", 32'(fb[0][0]), 32'h ff0);

        // Scrolling checker: committed at end of frame 2, inspected in frame 16 (offset 32).
        submit(3'd3, 1'b1, 12'h000, w);
        repeat (15) finish_frame();
        chk("scroll_f16_x0", 32'(fb[0][0]), 32'h000);
        chk("scroll_f16_x32", 32'(fb[0][32]), 32'h fff);
        chk("scroll_f16_x96", 32'(fb[0][96]), 32'h fff);
        submit(3'd3, 1'b0, 12'h000, w);
        finish_frame();
        finish_frame();
        chk("noscroll_x0", 32'(fb[0][0]), 32'h fff);
        chk("noscroll_x32", 32'(fb[0][32]), 32'h000);

        chk("latency_mismatch_count", 32'(lat_err), 0);
        chk("blanking_nonzero_count", 32'(blank_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
